mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised Memory→Writeback pipeline stage for the pipelined CPU: registers the memory-stage results (memory data, calculated data, destination register, control) on `clk`, then selects, aligns and sign/zero-extends the writeback value and drives the register-file write port. It generalises the fixed 16-bit MEM/WB register plus 2:1 writeback mux. It adds the following:

- Configurable data width.
- Stall and flush control.
- A valid bit.
- A 4-way writeback source.
- Sub-word load extraction.
- A retired-instruction counter.

## Interface
Parameters:
- `DATA_W`, 16: datapath width. Must be a multiple of 8 and ≥16.
- `RADDR_W`, 4: register-file address width.
- `CNT_W`, 16: width of the retired-instruction counter.
- `ZERO_REG`, 1: when 1, writes to register 0 are suppressed.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  hold the stage register unchanged.
- `flush`  in  1  insert a bubble into the stage register.
- `valid_in`  in  1  memory stage presents a real instruction.
- `wbs_in`  in  2  writeback source: 0 = calc, 1 = mem, 2 = link, 3 = zero.
- `memData_in`  in  DATA_W  raw data-memory read word.
- `calcData_in`  in  DATA_W  ALU/calculated result.
- `link_in`  in  DATA_W  return address (PC+1).
- `msize_in`  in  2  load size: 0 = word, 1 = byte, 2 = half; 3 is treated as word.
- `msigned_in`  in  1  1 = sign-extend sub-word load, 0 = zero-extend.
- `moff_in`  in  $clog2(DATA_W/8)  byte offset within the word.
- `rd_in`  in  RADDR_W  destination register.
- `regwrite_in`  in  1  instruction writes the register file.
- `ni_in`  in  1  next-instruction marker.
- `wb_valid`  out  1  stage holds a real instruction.
- `wb_we`  out  1  register-file write enable.
- `wb_rd`  out  RADDR_W  register-file write address.
- `wb_data`  out  DATA_W  register-file write data.
- `ni_out`  out  1  registered `ni_in`, gated by valid.
- `retired`  out  CNT_W  count of instructions accepted into the stage.

## Operation
- Stage register fields: `valid`, `wbs`, `memData`, `calcData`, `link`, `msize`, `msigned`, `moff`, `rd`, `regwrite`, `ni`.
- Update priority on each rising edge: `rst` > `flush` > `stall` > load.
  - `rst`: all fields cleared to 0 and `retired` set to 0.
  - `flush`: all fields cleared to 0. `retired` is unchanged. `flush` overrides a simultaneous `stall`.
  - `stall`: all fields and `retired` are held.
  - Load: every field captures its `_in` input, and `valid` captures `valid_in`.
- `retired` increments by 1 on a load cycle with `valid_in`=1. It wraps from 2^CNT_W−1 to 0.
- Sub-word extraction uses the registered `memData`, `moff` and `msize`:
  - Byte: `memData[8*moff +: 8]`.
  - Half: `memData[8*(moff & ~1) +: 16]`; the low offset bit is ignored.
  - Word: `memData` unchanged.
  - Sub-word results are extended to DATA_W. They are sign-extended when `msigned` is 1, zero-extended otherwise.
- `wb_data` is combinational from the stage register:
  - `wbs` = 0: `calcData`.
  - `wbs` = 1: the extracted memory value.
  - `wbs` = 2: `link`.
  - `wbs` = 3: 0.
- `wb_we` = `valid` & `regwrite` & !(ZERO_REG && `rd` == 0).
- `wb_rd` = `rd`. `wb_valid` = `valid`. `ni_out` = `ni` & `valid`.
- `msize` and `moff` affect `wb_data` only when `wbs` = 1.

## Timing
- Latency: inputs sampled at edge N appear on all outputs after edge N. Output logic is combinational from the register, so results are stable for the whole of cycle N+1.
- Throughput: one instruction per cycle when `stall`=0.
- Reset values: `wb_valid`, `wb_we` and `ni_out` are 0. `wb_rd` is 0. `wb_data` is 0 (`calcData` = 0 with `wbs` = 0). `retired` is 0.
- `rst` asserted mid-stream discards the held instruction at that edge. No write is issued in the following cycle.
- Under `stall`, `wb_we` keeps its current value, so a held valid instruction re-asserts the same write each stalled cycle. The write is idempotent, and the register file accepts the repetition.
- A flush-created bubble produces `wb_we`=0 and `ni_out`=0 in the next cycle.

## Test plan
- Reset and basic load:
  - Assert `rst` for 2 cycles → all outputs 0.
  - Then load `valid_in`=1, `wbs_in`=0, `calcData_in`=0xFF00, `rd_in`=3, `regwrite_in`=1.
  - After 1 edge → `wb_data`=0xFF00, `wb_we`=1, `wb_rd`=3, `retired`=1.
- Memory source with sub-word loads (`memData_in`=0x80FF, `wbs_in`=1):
  - byte, offset 1, signed → 0xFF80.
  - byte, offset 0, unsigned → 0x00FF.
  - word → 0x80FF.
- Stall and flush:
  - Load A (`calcData_in`=0x1234), then hold `stall`=1 for 3 cycles while the inputs change → `wb_data` stays 0x1234 and `retired` stays 1.
  - Assert `stall` and `flush` together → next cycle `wb_valid`=0, `wb_we`=0.
- Write suppression:
  - `rd_in`=0, `regwrite_in`=1, `valid_in`=1, ZERO_REG=1 → `wb_we`=0.
  - Same with `valid_in`=0 and `rd_in`=5 → `wb_we`=0, `ni_out`=0 even with `ni_in`=1.
- Link and zero sources:
  - `wbs_in`=2, `link_in`=0x0042 → `wb_data`=0x0042.
  - `wbs_in`=3 → `wb_data`=0x0000.
- Counter wrap: with CNT_W=4, 17 valid loads → `retired`=1.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback pipeline stage: registers memory-stage results, then selects,
// aligns and extends the writeback value and drives the register-file write port.
module mem_wb_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RADDR_W  = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic                          flush,
    input  logic                          valid_in,
    input  logic [1:0]                    wbs_in,
    input  logic [DATA_W-1:0]             memData_in,
    input  logic [DATA_W-1:0]             calcData_in,
    input  logic [DATA_W-1:0]             link_in,
    input  logic [1:0]                    msize_in,
    input  logic                          msigned_in,
    input  logic [$clog2(DATA_W/8)-1:0]   moff_in,
    input  logic [RADDR_W-1:0]            rd_in,
    input  logic                          regwrite_in,
    input  logic                          ni_in,
    output logic                          wb_valid,
    output logic                          wb_we,
    output logic [RADDR_W-1:0]            wb_rd,
    output logic [DATA_W-1:0]             wb_data,
    output logic                          ni_out,
    output logic [CNT_W-1:0]              retired
);

    localparam int unsigned OFF_W = $clog2(DATA_W / 8);

    localparam logic [1:0] WbsCalc = 2'd0;
    localparam logic [1:0] WbsMem  = 2'd1;
    localparam logic [1:0] WbsLink = 2'd2;

    localparam logic [1:0] SizeByte = 2'd1;
    localparam logic [1:0] SizeHalf = 2'd2;

    typedef struct packed {
        logic               valid;
        logic [1:0]         wbs;
        logic [DATA_W-1:0]  mem_data;
        logic [DATA_W-1:0]  calc_data;
        logic [DATA_W-1:0]  link;
        logic [1:0]         msize;
        logic               msigned;
        logic [OFF_W-1:0]   moff;
        logic [RADDR_W-1:0] rd;
        logic               regwrite;
        logic               ni;
    } stage_t;

    stage_t            stage_d, stage_q;
    logic [CNT_W-1:0]  retired_d, retired_q;

    logic [OFF_W-1:0]  half_off;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [DATA_W-1:0] mem_ext;

    always_comb begin
        stage_d   = stage_q;
        retired_d = retired_q;
        if (flush) begin
            stage_d = '0;
        end else if (!stall) begin
            stage_d.valid     = valid_in;
            stage_d.wbs       = wbs_in;
            stage_d.mem_data  = memData_in;
            stage_d.calc_data = calcData_in;
            stage_d.link      = link_in;
            stage_d.msize     = msize_in;
            stage_d.msigned   = msigned_in;
            stage_d.moff      = moff_in;
            stage_d.rd        = rd_in;
            stage_d.regwrite  = regwrite_in;
            stage_d.ni        = ni_in;
            if (valid_in) begin
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q   <= '0;
            retired_q <= '0;
        end else begin
            stage_q   <= stage_d;
            retired_q <= retired_d;
        end
    end

    // Shifting rather than part-selecting keeps every offset in range for any DATA_W.
    always_comb begin
        half_off    = stage_q.moff;
        half_off[0] = 1'b0;
        byte_val    = 8'(stage_q.mem_data >> {stage_q.moff, 3'b000});
        half_val    = 16'(stage_q.mem_data >> {half_off, 3'b000});
        case (stage_q.msize)
            SizeByte: begin
                mem_ext       = {DATA_W{stage_q.msigned & byte_val[7]}};
                mem_ext[7:0]  = byte_val;
            end
            SizeHalf: begin
                mem_ext       = {DATA_W{stage_q.msigned & half_val[15]}};
                mem_ext[15:0] = half_val;
            end
            default: mem_ext  = stage_q.mem_data;
        endcase
    end

    always_comb begin
        case (stage_q.wbs)
            WbsCalc: wb_data = stage_q.calc_data;
            WbsMem:  wb_data = mem_ext;
            WbsLink: wb_data = stage_q.link;
            default: wb_data = '0;
        endcase
    end

    assign wb_valid = stage_q.valid;
    assign wb_rd    = stage_q.rd;
    assign wb_we    = stage_q.valid & stage_q.regwrite
                    & ~((ZERO_REG != 0) && (stage_q.rd == '0));
    assign ni_out   = stage_q.ni & stage_q.valid;
    assign retired  = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed table-driven bench for mem_wb_stage; a second instance with a 4-bit
// counter shares the stimulus so counter wrap can be observed.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, valid_in, msigned_in, regwrite_in, ni_in;
    logic [1:0]  wbs_in, msize_in;
    logic [15:0] memData_in, calcData_in, link_in;
    logic [0:0]  moff_in;
    logic [3:0]  rd_in;

    logic        wb_valid, wb_we, ni_out;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data, retired;

    logic        wb_valid4, wb_we4, ni_out4;
    logic [3:0]  wb_rd4, retired4;
    logic [15:0] wb_data4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(16), .RADDR_W(4), .CNT_W(16), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .wbs_in(wbs_in), .memData_in(memData_in), .calcData_in(calcData_in),
        .link_in(link_in), .msize_in(msize_in), .msigned_in(msigned_in),
        .moff_in(moff_in), .rd_in(rd_in), .regwrite_in(regwrite_in), .ni_in(ni_in),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .ni_out(ni_out), .retired(retired)
    );

    mem_wb_stage #(.DATA_W(16), .RADDR_W(4), .CNT_W(4), .ZERO_REG(1)) u_dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
        .wbs_in(wbs_in), .memData_in(memData_in), .calcData_in(calcData_in),
        .link_in(link_in), .msize_in(msize_in), .msigned_in(msigned_in),
        .moff_in(moff_in), .rd_in(rd_in), .regwrite_in(regwrite_in), .ni_in(ni_in),
        .wb_valid(wb_valid4), .wb_we(wb_we4), .wb_rd(wb_rd4), .wb_data(wb_data4),
        .ni_out(ni_out4), .retired(retired4)
    );

    typedef struct {
        logic        rst, stall, flush, valid;
        logic [1:0]  wbs;
        logic [15:0] mem, calc, link;
        logic [1:0]  msize;
        logic        msigned;
        logic        moff;
        logic [3:0]  rd;
        logic        rw, ni;
        logic        e_valid, e_we;
        logic [3:0]  e_rd;
        logic [15:0] e_data;
        logic        e_ni;
        logic [15:0] e_ret;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, s, f, v, input logic [1:0] wbs,
                       input logic [15:0] mem, calc, link, input logic [1:0] msize,
                       input logic sg, off, input logic [3:0] rd, input logic rw, ni,
                       input logic ev, ewe, input logic [3:0] erd, input logic [15:0] edata,
                       input logic eni, input logic [15:0] eret);
        vec_t t;
        t.rst = r; t.stall = s; t.flush = f; t.valid = v; t.wbs = wbs;
        t.mem = mem; t.calc = calc; t.link = link; t.msize = msize;
        t.msigned = sg; t.moff = off; t.rd = rd; t.rw = rw; t.ni = ni;
        t.e_valid = ev; t.e_we = ewe; t.e_rd = erd; t.e_data = edata;
        t.e_ni = eni; t.e_ret = eret;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; stall = t.stall; flush = t.flush; valid_in = t.valid;
        wbs_in = t.wbs; memData_in = t.mem; calcData_in = t.calc; link_in = t.link;
        msize_in = t.msize; msigned_in = t.msigned; moff_in = t.moff;
        rd_in = t.rd; regwrite_in = t.rw; ni_in = t.ni;
    endtask

    task automatic check_outputs(input int idx, input vec_t t);
        string p;
        p = $sformatf("v%0d", idx);
        check({p, ".wb_valid"}, 32'(wb_valid), 32'(t.e_valid));
        check({p, ".wb_we"},    32'(wb_we),    32'(t.e_we));
        check({p, ".wb_rd"},    32'(wb_rd),    32'(t.e_rd));
        check({p, ".wb_data"},  32'(wb_data),  32'(t.e_data));
        check({p, ".ni_out"},   32'(ni_out),   32'(t.e_ni));
        check({p, ".retired"},  32'(retired),  32'(t.e_ret));
        check({p, ".wb_data4"}, 32'(wb_data4), 32'(t.e_data));
        check({p, ".wb_we4"},   32'(wb_we4),   32'(t.e_we));
        check({p, ".wb_valid4/rd4/ni4"}, {wb_valid4, wb_rd4, ni_out4},
              {t.e_valid, t.e_rd, t.e_ni});
        check({p, ".retired4"}, 32'(retired4), 32'(t.e_ret[3:0]));
    endtask

    initial begin
        //   r  s  f  v wbs mem      calc     link     sz sg of rd rw ni | ev we rd data    ni ret
        add(1, 0, 0, 1, 0, 16'h0000, 16'h5555, 16'h0000, 0, 0, 0, 3, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
        add(1, 0, 0, 1, 0, 16'h0000, 16'h5555, 16'h0000, 0, 0, 0, 3, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0000, 16'hFF00, 16'h0000, 0, 0, 0, 3, 1, 0, 1, 1, 3, 16'hFF00, 0, 1);
        add(0, 0, 0, 1, 1, 16'h80FF, 16'h0000, 16'h0000, 1, 1, 1, 4, 1, 0, 1, 1, 4, 16'hFF80, 0, 2);
        add(0, 0, 0, 1, 1, 16'h80FF, 16'h0000, 16'h0000, 1, 0, 0, 4, 1, 0, 1, 1, 4, 16'h00FF, 0, 3);
        add(0, 0, 0, 1, 1, 16'h80FF, 16'h0000, 16'h0000, 0, 1, 1, 4, 1, 0, 1, 1, 4, 16'h80FF, 0, 4);
        add(0, 0, 0, 1, 1, 16'h80FF, 16'h0000, 16'h0000, 2, 1, 1, 4, 1, 0, 1, 1, 4, 16'h80FF, 0, 5);
        add(0, 0, 0, 1, 1, 16'h80FF, 16'h0000, 16'h0000, 1, 0, 1, 4, 1, 0, 1, 1, 4, 16'h0080, 0, 6);
        add(0, 0, 0, 1, 1, 16'h80FF, 16'h0000, 16'h0000, 1, 1, 0, 4, 1, 0, 1, 1, 4, 16'hFFFF, 0, 7);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h1111, 16'h0000, 0, 0, 0, 0, 1, 0, 1, 0, 0, 16'h1111, 0, 8);
        add(0, 0, 0, 0, 0, 16'h0000, 16'h2222, 16'h0000, 0, 0, 0, 5, 1, 1, 0, 0, 5, 16'h2222, 0, 8);
        add(0, 0, 0, 1, 2, 16'h0000, 16'h0000, 16'h0042, 0, 0, 0, 5, 1, 1, 1, 1, 5, 16'h0042, 1, 9);
        add(0, 0, 0, 1, 3, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 6, 1, 0, 1, 1, 6, 16'h0000, 0, 10);
        add(0, 0, 0, 1, 0, 16'h0000, 16'hABCD, 16'h0000, 0, 0, 0, 7, 0, 0, 1, 0, 7, 16'hABCD, 0, 11);
        add(0, 0, 0, 1, 1, 16'h80FF, 16'h0000, 16'h0000, 3, 1, 1, 8, 1, 0, 1, 1, 8, 16'h80FF, 0, 12);
        // Load A, then three stalled cycles with changing inputs hold it
        add(0, 0, 0, 1, 0, 16'h0000, 16'h1234, 16'h0000, 0, 0, 0, 2, 1, 1, 1, 1, 2, 16'h1234, 1, 13);
        add(0, 1, 0, 1, 0, 16'h0000, 16'h9999, 16'h0000, 0, 0, 0, 9, 1, 0, 1, 1, 2, 16'h1234, 1, 13);
        add(0, 1, 0, 1, 1, 16'h1357, 16'h8888, 16'h0000, 1, 1, 1, 9, 0, 0, 1, 1, 2, 16'h1234, 1, 13);
        add(0, 1, 0, 0, 2, 16'h0000, 16'h7777, 16'h5A5A, 0, 0, 0, 1, 1, 1, 1, 1, 2, 16'h1234, 1, 13);
        add(0, 1, 1, 1, 0, 16'h0000, 16'h7777, 16'h0000, 0, 0, 0, 9, 1, 1, 0, 0, 0, 16'h0000, 0, 13);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h4321, 16'h0000, 0, 0, 0, 1, 1, 1, 1, 1, 1, 16'h4321, 1, 14);
        add(1, 1, 0, 1, 0, 16'h0000, 16'h6666, 16'h0000, 0, 0, 0, 3, 1, 1, 0, 0, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 1, 0, 16'h0000, 16'h0101, 16'h0000, 0, 0, 0, 2, 1, 1, 1, 1, 2, 16'h0101, 1, 1);
        add(0, 0, 1, 1, 0, 16'h0000, 16'h0202, 16'h0000, 0, 0, 0, 2, 1, 1, 0, 0, 0, 16'h0000, 0, 1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_outputs(i, vecs[i]);
            @(negedge clk);
        end

        // Counter wrap: 16 valid loads return the 4-bit counter to 0, the 17th gives 1
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        @(posedge clk);
        #1;
        check("wrap.reset", 32'(retired4), 32'd0);
        @(negedge clk);
        rst = 1'b0; valid_in = 1'b1; wbs_in = 2'd0; rd_in = 4'd1; regwrite_in = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            calcData_in = 16'(k);
            @(posedge clk);
            #1;
            if (k == 16) check("wrap.16", 32'(retired4), 32'd0);
            @(negedge clk);
        end
        check("wrap.17", 32'(retired4), 32'd1);
        check("wrap.17_wide", 32'(retired), 32'd17);
        check("wrap.17_data", 32'(wb_data4), 32'd17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
